// File: rtl/aq_gemac_rx_ctrl_if.sv
// aq_gemac_rx_ctrl_if: receive buffer write port.
// The MAC side is master; the buffer side is slave and returns BUFF_FULL.
interface aq_gemac_rx_ctrl_if;
    logic        BUFF_FULL;
    logic        BUFF_WE;
    logic        BUFF_START;
    logic        BUFF_END;
    logic [7:0]  BUFF_DATA;
    logic [15:0] BUFF_STATUS;

    modport master (
        input  BUFF_FULL,
        output BUFF_WE,
        output BUFF_START,
        output BUFF_END,
        output BUFF_DATA,
        output BUFF_STATUS
    );

    modport slave (
        output BUFF_FULL,
        input  BUFF_WE,
        input  BUFF_START,
        input  BUFF_END,
        input  BUFF_DATA,
        input  BUFF_STATUS
    );
endinterface

// File: rtl/aq_gemac_rx_ctrl.sv
// aq_gemac_rx_ctrl: GMII receive framer writing frames plus a
// two-word trailer into a receive buffer, with status and counters.
module aq_gemac_rx_ctrl #(
    parameter int MAX_LEN = 1518
) (
    input  logic                      MAC_CLK,
    input  logic                      RST_N,
    input  logic                      RX_DV,
    input  logic                      RX_ER,
    input  logic [7:0]                RXD,
    input  logic [47:0]               MAC_ADDR,
    aq_gemac_rx_ctrl_if.master        buff,
    output logic [15:0]               FRAME_COUNT,
    output logic [15:0]               DROP_COUNT
);

    typedef enum logic [2:0] {
        IDLE, PRE, DATA, TRL1, TRL2, OVF, SKIP
    } state_t;

    localparam logic [15:0] MAX_L = 16'(MAX_LEN);
    // Register value after a good FCS; bit-reversed form of 0xC704DD7B.
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    state_t      state;
    logic [7:0]  hold;
    logic        have;
    logic        first;
    logic [31:0] crc;
    logic [15:0] len;
    logic        da_bc;
    logic        da_me;
    logic        da_mc;
    logic        er;
    logic        ovf;

    logic [7:0]  mac_byte;
    logic [15:0] len_inc;
    logic        short_da;
    logic        er_now;
    logic [15:0] status_now;

    // Station address byte matching the current DA position, and the
    // status word as it would stand if the frame ended this cycle.
    always_comb begin
        mac_byte = 8'h00;
        case (len[2:0])
            3'd0: mac_byte = MAC_ADDR[47:40];
            3'd1: mac_byte = MAC_ADDR[39:32];
            3'd2: mac_byte = MAC_ADDR[31:24];
            3'd3: mac_byte = MAC_ADDR[23:16];
            3'd4: mac_byte = MAC_ADDR[15:8];
            3'd5: mac_byte = MAC_ADDR[7:0];
            default: mac_byte = 8'h00;
        endcase
        len_inc    = (len == 16'hFFFF) ? len : len + 16'd1;
        short_da   = len < 16'd6;
        er_now     = er | ((state == DATA) & RX_ER);
        status_now = {8'h00,
                      ~short_da & da_me,
                      ~short_da & da_mc & ~da_bc,
                      ~short_da & da_bc,
                      ovf,
                      len > MAX_L,
                      len < 16'd64,
                      er_now,
                      crc != RESIDUE};
    end

    // Receive FSM with registered buffer outputs and counters.
    always_ff @(posedge MAC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state            <= IDLE;
            hold             <= 8'h00;
            have             <= 1'b0;
            first            <= 1'b0;
            crc              <= 32'hFFFFFFFF;
            len              <= 16'h0000;
            da_bc            <= 1'b0;
            da_me            <= 1'b0;
            da_mc            <= 1'b0;
            er               <= 1'b0;
            ovf              <= 1'b0;
            buff.BUFF_WE     <= 1'b0;
            buff.BUFF_START  <= 1'b0;
            buff.BUFF_END    <= 1'b0;
            buff.BUFF_DATA   <= 8'h00;
            buff.BUFF_STATUS <= 16'h0000;
            FRAME_COUNT      <= 16'h0000;
            DROP_COUNT       <= 16'h0000;
        end else begin
            buff.BUFF_WE    <= 1'b0;
            buff.BUFF_START <= 1'b0;
            buff.BUFF_END   <= 1'b0;
            buff.BUFF_DATA  <= 8'h00;
            unique case (state)
                IDLE: begin
                    if (RX_DV && RXD == 8'h55)
                        state <= PRE;
                end
                PRE: begin
                    if (!RX_DV) begin
                        state <= IDLE;
                    end else if (RXD == 8'hD5) begin
                        if (buff.BUFF_FULL) begin
                            state      <= SKIP;
                            DROP_COUNT <= DROP_COUNT + 16'd1;
                        end else begin
                            state <= DATA;
                            crc   <= 32'hFFFFFFFF;
                            len   <= 16'h0000;
                            have  <= 1'b0;
                            first <= 1'b1;
                            da_bc <= 1'b1;
                            da_me <= 1'b1;
                            da_mc <= 1'b0;
                            er    <= 1'b0;
                            ovf   <= 1'b0;
                        end
                    end else if (RXD != 8'h55) begin
                        state <= SKIP;
                    end
                end
                DATA: begin
                    if (RX_ER)
                        er <= 1'b1;
                    if (buff.BUFF_FULL) begin
                        ovf   <= 1'b1;
                        state <= OVF;
                    end else if (RX_DV) begin
                        if (have) begin
                            buff.BUFF_WE    <= 1'b1;
                            buff.BUFF_START <= first;
                            buff.BUFF_DATA  <= hold;
                            first           <= 1'b0;
                        end
                        hold <= RXD;
                        have <= 1'b1;
                        crc  <= crc_byte(crc, RXD);
                        len  <= len_inc;
                        if (short_da) begin
                            da_bc <= da_bc & (RXD == 8'hFF);
                            da_me <= da_me & (RXD == mac_byte);
                            if (len == 16'd0)
                                da_mc <= RXD[0];
                        end
                    end else if (have) begin
                        buff.BUFF_WE     <= 1'b1;
                        buff.BUFF_START  <= first;
                        buff.BUFF_END    <= 1'b1;
                        buff.BUFF_DATA   <= hold;
                        buff.BUFF_STATUS <= status_now;
                        state            <= TRL1;
                    end else begin
                        // SFD followed by nothing: no frame to report.
                        state <= IDLE;
                    end
                end
                OVF: begin
                    if (!RX_DV && !buff.BUFF_FULL) begin
                        buff.BUFF_WE     <= 1'b1;
                        buff.BUFF_END    <= 1'b1;
                        buff.BUFF_STATUS <= status_now;
                        DROP_COUNT       <= DROP_COUNT + 16'd1;
                        state            <= TRL1;
                    end
                end
                TRL1: begin
                    buff.BUFF_WE <= 1'b1;
                    state        <= TRL2;
                end
                TRL2: begin
                    buff.BUFF_WE <= 1'b1;
                    FRAME_COUNT  <= FRAME_COUNT + 16'd1;
                    state        <= IDLE;
                end
                SKIP: begin
                    if (!RX_DV)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aq_gemac_rx_ctrl.sv
// tb_aq_gemac_rx_ctrl: frame-level vectors for the GMII receive framer,
// plus hand-written overflow and mid-frame reset sequences.
module tb_aq_gemac_rx_ctrl;

    localparam logic [47:0] MAC = 48'h02AABBCCDDEE;
    localparam int NV = 12;

    logic        MAC_CLK;
    logic        RST_N;
    logic        RX_DV;
    logic        RX_ER;
    logic [7:0]  RXD;
    logic [47:0] MAC_ADDR;
    logic [15:0] FRAME_COUNT;
    logic [15:0] DROP_COUNT;

    aq_gemac_rx_ctrl_if bus();

    aq_gemac_rx_ctrl #(.MAX_LEN(1518)) dut (
        .MAC_CLK     (MAC_CLK),
        .RST_N       (RST_N),
        .RX_DV       (RX_DV),
        .RX_ER       (RX_ER),
        .RXD         (RXD),
        .MAC_ADDR    (MAC_ADDR),
        .buff        (bus.master),
        .FRAME_COUNT (FRAME_COUNT),
        .DROP_COUNT  (DROP_COUNT)
    );

    // kind: 0 = station, 1 = broadcast, 2 = multicast, 3 = other unicast
    typedef struct {
        int          len;
        int          kind;
        bit          bad_fcs;
        int          er_at;
        bit          full_sfd;
        logic [15:0] status;
        int          fc;
        int          dc;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       e;
    } wr_t;

    vec_t        vt [NV];
    wr_t         wq [$];
    logic [7:0]  frm [0:2047];
    int          total;
    int          bad;
    int          stray;
    logic [15:0] mon_status;

    initial MAC_CLK = 1'b0;
    always #4 MAC_CLK = ~MAC_CLK;

    always @(negedge MAC_CLK) begin
        if (bus.BUFF_WE) begin
            wq.push_back('{d: bus.BUFF_DATA, s: bus.BUFF_START,
                           e: bus.BUFF_END});
            if (bus.BUFF_END)
                mon_status <= bus.BUFF_STATUS;
        end else if (bus.BUFF_START || bus.BUFF_END) begin
            stray <= stray + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_ref(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int b = 0; b < n; b++)
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ frm[b][k];
                c  = c >> 1;
                if (fb)
                    c = c ^ 32'hEDB88320;
            end
        return c;
    endfunction

    task automatic build(input int len, input int kind, input bit bad_fcs);
        logic [47:0] da;
        logic [31:0] c;
        case (kind)
            0:       da = MAC;
            1:       da = 48'hFFFFFFFFFFFF;
            2:       da = 48'h01005E000001;
            default: da = 48'h02AABBCCDDEF;
        endcase
        for (int i = 0; i < len; i++)
            frm[i] = (i < 6) ? 8'(da >> (8 * (5 - i))) : 8'(i * 7 + 3);
        if (len >= 5) begin
            c = ~crc_ref(len - 4);
            for (int j = 0; j < 4; j++)
                frm[len - 4 + j] = 8'(c >> (8 * j));
            if (bad_fcs)
                frm[len - 1] = frm[len - 1] ^ 8'h01;
        end
    endtask

    // Drives preamble, SFD and frm[0..len-1]; returns early with reset
    // asserted when rst_at is reached.
    task automatic send(input int len, input int er_at, input bit full_sfd,
                        input int full_at, input int rst_at);
        @(negedge MAC_CLK);
        for (int i = 0; i < 7; i++) begin
            RX_DV = 1'b1;
            RXD   = 8'h55;
            @(negedge MAC_CLK);
        end
        if (full_sfd)
            bus.BUFF_FULL = 1'b1;
        RXD = 8'hD5;
        @(negedge MAC_CLK);
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) begin
                #2;
                RST_N = 1'b0;
                RX_DV = 1'b0;
                RX_ER = 1'b0;
                RXD   = 8'h00;
                return;
            end
            if (i == full_at)
                bus.BUFF_FULL = 1'b1;
            RXD   = frm[i];
            RX_ER = (i == er_at);
            @(negedge MAC_CLK);
        end
        RX_DV = 1'b0;
        RX_ER = 1'b0;
        RXD   = 8'h00;
        repeat (3) @(negedge MAC_CLK);
        bus.BUFF_FULL = 1'b0;
        repeat (8) @(negedge MAC_CLK);
    endtask

    task automatic check_writes(input string nm, input int n, input bit ovf);
        int         errs;
        logic [7:0] ed;
        logic       es;
        logic       ee;
        check({nm, "_nwr"}, 32'(wq.size()), 32'(n + (ovf ? 3 : 2)));
        errs = 0;
        foreach (wq[i]) begin
            if (i < n) begin
                ed = frm[i];
                es = (i == 0);
                ee = !ovf && (i == n - 1);
            end else begin
                ed = 8'h00;
                es = 1'b0;
                ee = ovf && (i == n);
            end
            if (wq[i].d !== ed || wq[i].s !== es || wq[i].e !== ee)
                errs++;
        end
        check({nm, "_seq"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int nend;
        total         = 0;
        bad           = 0;
        stray         = 0;
        mon_status    = 16'h0000;
        RST_N         = 1'b1;
        RX_DV         = 1'b0;
        RX_ER         = 1'b0;
        RXD           = 8'h00;
        MAC_ADDR      = MAC;
        bus.BUFF_FULL = 1'b0;

        //            len  kind bad er  full status    fc  dc
        vt[0]  = '{  64,  0,  0, -1,  0, 16'h0080,  1, 0};
        vt[1]  = '{  64,  0,  1, 30,  0, 16'h0083,  2, 0};
        vt[2]  = '{  60,  1,  0, -1,  0, 16'h0024,  3, 0};
        vt[3]  = '{1600,  3,  0, -1,  0, 16'h0008,  4, 0};
        vt[4]  = '{  64,  0,  0, -1,  1, 16'h0000,  4, 1};
        vt[5]  = '{   1,  1,  0, -1,  0, 16'h0005,  5, 1};
        vt[6]  = '{  64,  2,  0, -1,  0, 16'h0040,  6, 1};
        vt[7]  = '{1518,  0,  0, -1,  0, 16'h0080,  7, 1};
        vt[8]  = '{1519,  0,  0, -1,  0, 16'h0088,  8, 1};
        vt[9]  = '{   5,  1,  0, -1,  0, 16'h0004,  9, 1};
        vt[10] = '{  63,  0,  0, -1,  0, 16'h0084, 10, 1};
        vt[11] = '{  64,  3,  1, -1,  0, 16'h0001, 11, 1};

        #3;
        RST_N = 1'b0;
        repeat (2) @(negedge MAC_CLK);
        check("rst_we", 32'(bus.BUFF_WE), 32'd0);
        check("rst_status", 32'(bus.BUFF_STATUS), 32'd0);
        check("rst_fc", 32'(FRAME_COUNT), 32'd0);
        check("rst_dc", 32'(DROP_COUNT), 32'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge MAC_CLK);

        for (int k = 0; k < NV; k++) begin
            wq.delete();
            build(vt[k].len, vt[k].kind, vt[k].bad_fcs);
            send(vt[k].len, vt[k].er_at, vt[k].full_sfd, -1, -1);
            if (vt[k].full_sfd) begin
                check($sformatf("v%0d_skip_nwr", k), 32'(wq.size()), 32'd0);
            end else begin
                check_writes($sformatf("v%0d", k), vt[k].len, 1'b0);
                check($sformatf("v%0d_status_end", k),
                      32'(mon_status), 32'(vt[k].status));
                check($sformatf("v%0d_status_hold", k),
                      32'(bus.BUFF_STATUS), 32'(vt[k].status));
            end
            check($sformatf("v%0d_fc", k), 32'(FRAME_COUNT), 32'(vt[k].fc));
            check($sformatf("v%0d_dc", k), 32'(DROP_COUNT), 32'(vt[k].dc));
        end

        // Buffer fills after 20 bytes have been written.
        wq.delete();
        build(64, 0, 1'b0);
        send(64, -1, 1'b0, 21, -1);
        check_writes("ovf", 20, 1'b1);
        check("ovf_status4", 32'(mon_status[4]), 32'd1);
        check("ovf_fc", 32'(FRAME_COUNT), 32'd12);
        check("ovf_dc", 32'(DROP_COUNT), 32'd2);

        // Reset lands at byte 30 of a frame.
        wq.delete();
        build(64, 0, 1'b0);
        send(64, -1, 1'b0, -1, 30);
        #1;
        check("mid_rst_we", 32'(bus.BUFF_WE), 32'd0);
        check("mid_rst_start", 32'(bus.BUFF_START), 32'd0);
        check("mid_rst_end", 32'(bus.BUFF_END), 32'd0);
        check("mid_rst_data", 32'(bus.BUFF_DATA), 32'd0);
        check("mid_rst_status", 32'(bus.BUFF_STATUS), 32'd0);
        check("mid_rst_fc", 32'(FRAME_COUNT), 32'd0);
        check("mid_rst_dc", 32'(DROP_COUNT), 32'd0);
        nend = 0;
        foreach (wq[i])
            if (wq[i].e)
                nend++;
        check("mid_rst_nwr", 32'(wq.size()), 32'd29);
        check("mid_rst_noend", 32'(nend), 32'd0);
        repeat (3) @(negedge MAC_CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge MAC_CLK);

        wq.delete();
        send(64, -1, 1'b0, -1, -1);
        check_writes("post_rst", 64, 1'b0);
        check("post_rst_status", 32'(mon_status), 32'h0080);
        check("post_rst_fc", 32'(FRAME_COUNT), 32'd1);
        check("post_rst_dc", 32'(DROP_COUNT), 32'd0);

        check("stray_flags", 32'(stray), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aq_gemac_rx_ctrl.md
AQ_GEMAC_RX_CTRL -- requirements
Module: aq_gemac_rx_ctrl

Interface
REQ-001 Parameter: MAX_LEN, 1518, longest legal frame in bytes (DA through FCS inclusive).
REQ-002 Reset is RST_N, asynchronous, active-low; clock is MAC_CLK.
REQ-003 MAC_CLK  in  1  receive byte clock; all other ports are synchronous to it.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 RX_DV  in  1  GMII receive data valid.
REQ-006 RX_ER  in  1  GMII receive error.
REQ-007 RXD  in  8  GMII receive byte.
REQ-008 MAC_ADDR  in  48  station address; byte 0 (first on wire) = MAC_ADDR[47:40].
REQ-009 BUFF_FULL  in  1  receive buffer full.
REQ-010 BUFF_WE  out  1  byte or trailer write strobe to the receive buffer.
REQ-011 BUFF_START  out  1  first frame byte marker, qualified by BUFF_WE.
REQ-012 BUFF_END  out  1  last frame byte marker, qualified by BUFF_WE.
REQ-013 BUFF_DATA  out  8  frame byte.
REQ-014 BUFF_STATUS  out  16  frame status word.
REQ-015 FRAME_COUNT  out  16  frames delivered, wraps at 16 bits.
REQ-016 DROP_COUNT  out  16  frames lost to full, wraps at 16 bits.

Function
REQ-017 States SHALL be IDLE, PRE, DATA, TRL1, TRL2, OVF, SKIP.
REQ-018 IDLE: RX_DV=1 and RXD=0x55 SHALL go to PRE; all other inputs keep IDLE.
REQ-019 PRE: RXD=0xD5 with RX_DV=1 SHALL go to DATA if BUFF_FULL=0, else go to SKIP and increment DROP_COUNT.
REQ-020 PRE: RXD=0x55 SHALL hold PRE; RX_DV=0 SHALL go to IDLE; any other byte SHALL go to SKIP without counting.
REQ-021 SKIP SHALL wait for RX_DV=0, then go to IDLE; no buffer writes occur in SKIP.
REQ-022 DATA: a byte sampled at edge k SHALL be driven on BUFF_DATA with BUFF_WE=1 after edge k+1 (one-cycle latency).
REQ-023 The first byte after SFD SHALL carry BUFF_START=1.
REQ-024 If RX_DV=0 at edge k+1, that byte SHALL carry BUFF_END=1 and the state SHALL go to TRL1.
REQ-025 A single-byte frame SHALL carry BUFF_START=1 and BUFF_END=1 together.
REQ-026 TRL1 and TRL2 SHALL each drive BUFF_WE=1, BUFF_START=0, BUFF_END=0, BUFF_DATA=0x00, then return to IDLE.
REQ-027 FRAME_COUNT SHALL increment on the TRL2 cycle; RX_DV SHALL be ignored in TRL1 and TRL2.
REQ-028 BUFF_STATUS SHALL be valid from the BUFF_END cycle and held until the next BUFF_START.
REQ-029 BUFF_STATUS bits SHALL be:
- [0] CRC error: CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) over all bytes including FCS, with residue != 0xC704DD7B.
- [1] RX_ER was sampled high during DATA.
- [2] runt: length < 64.
- [3] long: length > MAX_LEN.
- [4] overflow.
- [5] DA = FF:FF:FF:FF:FF:FF.
- [6] DA byte 0 bit 0 = 1 and not broadcast.
- [7] DA = MAC_ADDR.
- [15:8] = 0.
REQ-030 Length SHALL count bytes after SFD including FCS, saturating at 0xFFFF; DA flags evaluate to 0 for frames shorter than 6 bytes.
REQ-031 DATA with BUFF_FULL=1 SHALL suppress BUFF_WE, discard further bytes, set status[4], and go to OVF.
REQ-032 OVF SHALL wait until RX_DV=0 and BUFF_FULL=0, then emit one BUFF_WE cycle with BUFF_END=1 and BUFF_DATA=0x00, increment DROP_COUNT, and go to TRL1.
REQ-033 Outside active write cycles, BUFF_WE, BUFF_START and BUFF_END SHALL be 0.

Reset
REQ-034 On RST_N=0 (including mid-frame) the state SHALL go to IDLE, all outputs and counters SHALL be 0, and the CRC SHALL be 0xFFFFFFFF; a partial frame is abandoned without a trailer.

Verification
REQ-035 7x0x55, 0xD5, 64-byte frame with correct FCS, DA=MAC_ADDR -> 64 writes with START on the first and END on the last, 2 trailer writes, STATUS=0x0080, FRAME_COUNT=1.
REQ-036 Same frame with one corrupted FCS byte and RX_ER pulsed mid-frame -> STATUS=0x0083.
REQ-037 BUFF_FULL=1 at SFD -> no BUFF_WE for the whole frame, DROP_COUNT=1, FRAME_COUNT=0.
REQ-038 BUFF_FULL rises after byte 20 and falls after RX_DV drops -> 20 byte writes, then a 0x00 END write, then 2 trailer writes; status[4]=1, DROP_COUNT=1, FRAME_COUNT=1.
REQ-039 Broadcast 60-byte frame, then a 1600-byte frame with MAX_LEN=1518 -> STATUS 0x0024 then long bit set; FRAME_COUNT=2.
REQ-040 RST_N asserted at byte 30 of a frame -> all outputs 0 immediately; the next frame is received normally.
